// File: rtl/quad_decoder.sv
// Purpose : x4 quadrature decoder with per-channel synchroniser and glitch filter, signed wrapping count.
// Latency : a stable new A/B level first sampled on edge 1 updates count/step/dir on edge SYNC_STAGES+FILT_LEN+1.
// Backpr. : none; free-running decoder, every output is a registered level or a one-cycle pulse.
//
// Ports   : clk, rst_n (async active-low); A, B raw encoder channels; clr clears count;
//           err_clr clears err; count signed position; dir 00 idle / 01 CW / 10 CCW;
//           step one-cycle pulse per valid transition; err sticky illegal-transition flag.
// Option  : QUAD_DECODER_INDEX_EN adds index input Z and pulse output idx; a filtered Z rising
//           edge zeroes count (clr still has priority).
module quad_decoder #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int IDLE_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A,
    input  logic             B,
`ifdef QUAD_DECODER_INDEX_EN
    input  logic             Z,
`endif
    input  logic             clr,
    input  logic             err_clr,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       dir,
    output logic             step,
    output logic             err
`ifdef QUAD_DECODER_INDEX_EN
    ,
    output logic             idx
`endif
);

`ifdef QUAD_DECODER_INDEX_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 2;
`endif
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int IW = $clog2(IDLE_CYCLES + 1);

    // Channel packing: bit1 = A, bit0 = B, bit2 = Z when the index is enabled.
    logic [NCH-1:0] raw;
`ifdef QUAD_DECODER_INDEX_EN
    assign raw = {Z, A, B};
`else
    assign raw = {A, B};
`endif

    logic [SYNC_STAGES-1:0][NCH-1:0] sync_q;
    logic [NCH-1:0]                  sync_out;
    logic [NCH-1:0]                  filt;
    logic [FW-1:0]                   fcnt [NCH];
    logic [1:0]                      p_q;
    logic [IW-1:0]                   idle_q;
    logic [IW-1:0]                   idle_inc;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // A channel only adopts a new level after FILT_LEN consecutive disagreeing
    // samples; any agreeing sample restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= '0;
            for (int i = 0; i < NCH; i++) fcnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync_out[i] != filt[i]) begin
                    if (fcnt[i] == FW'(FILT_LEN - 1)) begin
                        filt[i] <= sync_out[i];
                        fcnt[i] <= '0;
                    end else begin
                        fcnt[i] <= fcnt[i] + FW'(1);
                    end
                end else begin
                    fcnt[i] <= '0;
                end
            end
        end
    end

    // Clockwise successor in the Gray sequence 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] cw_next(input logic [1:0] s);
        case (s)
            2'b00:   cw_next = 2'b10;
            2'b10:   cw_next = 2'b11;
            2'b11:   cw_next = 2'b01;
            default: cw_next = 2'b00;
        endcase
    endfunction

    logic [1:0] s_cur;
    logic       cw_mv;
    logic       ccw_mv;
    logic       illegal;
    logic       z_rise;

    assign s_cur   = filt[1:0];
    assign cw_mv   = (s_cur == cw_next(p_q));
    assign ccw_mv  = (p_q == cw_next(s_cur));
    assign illegal = (s_cur == ~p_q);

`ifdef QUAD_DECODER_INDEX_EN
    logic z_prev;
    assign z_rise = filt[2] & ~z_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_prev <= 1'b0;
            idx    <= 1'b0;
        end else begin
            z_prev <= filt[2];
            idx    <= z_rise;
        end
    end
`else
    assign z_rise = 1'b0;
`endif

    // Idle counter saturates at IDLE_CYCLES; illegal transitions do not reset it.
    assign idle_inc = (idle_q == IW'(IDLE_CYCLES)) ? idle_q : idle_q + IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q    <= 2'b00;
            idle_q <= '0;
            count  <= '0;
            dir    <= 2'b00;
            step   <= 1'b0;
            err    <= 1'b0;
        end else begin
            p_q  <= s_cur;
            step <= cw_mv | ccw_mv;
            err  <= illegal | (err & ~err_clr);

            if (cw_mv || ccw_mv) begin
                idle_q <= '0;
            end else begin
                idle_q <= idle_inc;
            end

            if (cw_mv) begin
                dir <= 2'b01;
            end else if (ccw_mv) begin
                dir <= 2'b10;
            end else if (idle_inc == IW'(IDLE_CYCLES)) begin
                dir <= 2'b00;
            end

            if (clr || z_rise) begin
                count <= '0;
            end else if (cw_mv) begin
                count <= count + CNT_W'(1);
            end else if (ccw_mv) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Purpose : self-checking bench for quad_decoder with a sample-window behavioural model.
// Latency : model predicts outputs cycle by cycle; checks run 1 time unit after each rising edge.
// Backpr. : none; stimulus is driven on falling edges.
module tb_quad_decoder;
    localparam int CNT_W = 16;
    localparam int SYNC  = 2;
    localparam int FILT  = 3;
    localparam int IDLE  = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic A = 1'b0;
    logic B = 1'b0;
    logic clr = 1'b0;
    logic err_clr = 1'b0;
    logic [CNT_W-1:0] count;
    logic [1:0] dir;
    logic step;
    logic err;
`ifdef QUAD_DECODER_INDEX_EN
    logic Z = 1'b0;
    logic idx;
`endif

    always #5 clk = ~clk;

    quad_decoder #(
        .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .FILT_LEN(FILT), .IDLE_CYCLES(IDLE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .A(A),
        .B(B),
`ifdef QUAD_DECODER_INDEX_EN
        .Z(Z),
`endif
        .clr(clr),
        .err_clr(err_clr),
        .count(count),
        .dir(dir),
        .step(step),
        .err(err)
`ifdef QUAD_DECODER_INDEX_EN
        ,
        .idx(idx)
`endif
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [2:0] hist[$];          // raw {Z,A,B} per edge, newest first
    logic [2:0] f_cur, f_old;     // filtered level after the last edge and the one before
    logic [CNT_W-1:0] m_count;
    logic [1:0] m_dir;
    logic m_step, m_err, m_idx;
    longint edge_n = 0;
    longint last_step_edge = 0;
    int step_seen = 0;
    int idx_seen = 0;

    function automatic int pos_of(input logic [1:0] s);
        case (s)
            2'b00:   pos_of = 0;
            2'b10:   pos_of = 1;
            2'b11:   pos_of = 2;
            default: pos_of = 3;
        endcase
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SYNC + FILT; i++) hist.push_back(3'b000);
        f_cur = '0;
        f_old = '0;
        m_count = '0;
        m_dir = 2'b00;
        m_step = 1'b0;
        m_err = 1'b0;
        m_idx = 1'b0;
        last_step_edge = edge_n;
    endtask

    task automatic model_edge(input logic [2:0] smp, input logic c_clr, input logic c_eclr);
        int d;
        logic [2:0] nf;
        d = (pos_of(f_cur[1:0]) - pos_of(f_old[1:0]) + 4) % 4;
        m_step = (d == 1) || (d == 3);
        if (d == 1) begin
            m_count = m_count + 1'b1;
            m_dir = 2'b01;
            last_step_edge = edge_n;
        end else if (d == 3) begin
            m_count = m_count - 1'b1;
            m_dir = 2'b10;
            last_step_edge = edge_n;
        end else if (edge_n - last_step_edge >= IDLE) begin
            m_dir = 2'b00;
        end
        m_err = (d == 2) || (m_err && !c_eclr);
        m_idx = f_cur[2] && !f_old[2];
        if (m_idx || c_clr) m_count = '0;
        // A filtered level follows the raw level once the FILT samples the
        // filter has seen (delayed by SYNC) all agree on a different value.
        hist.push_front(smp);
        void'(hist.pop_back());
        nf = f_cur;
        for (int c = 0; c < 3; c++) begin
            logic same;
            same = 1'b1;
            for (int i = 0; i < FILT; i++)
                if (hist[SYNC + i][c] != hist[SYNC][c]) same = 1'b0;
            if (same && hist[SYNC][c] != f_cur[c]) nf[c] = hist[SYNC][c];
        end
        f_old = f_cur;
        f_cur = nf;
    endtask

    always @(posedge clk) begin
        logic [2:0] smp;
        logic r_rst, r_clr, r_eclr;
`ifdef QUAD_DECODER_INDEX_EN
        smp = {Z, A, B};
`else
        smp = {1'b0, A, B};
`endif
        r_rst = rst_n;
        r_clr = clr;
        r_eclr = err_clr;
        #1;
        edge_n++;
        if (!r_rst) model_reset();
        else model_edge(smp, r_clr, r_eclr);
        chk("cyc_count", 32'(count), 32'(m_count));
        chk("cyc_dir", 32'(dir), 32'(m_dir));
        chk("cyc_step", 32'(step), 32'(m_step));
        chk("cyc_err", 32'(err), 32'(m_err));
        if (step === 1'b1) step_seen++;
`ifdef QUAD_DECODER_INDEX_EN
        chk("cyc_idx", 32'(idx), 32'(m_idx));
        if (idx === 1'b1) idx_seen++;
`endif
    end

    // ---------------- stimulus ----------------
    logic [1:0] cw_seq [4];
    int cur = 0;

    task automatic drive_ab(input logic [1:0] s, input int hold);
        A = s[1];
        B = s[0];
        repeat (hold) @(negedge clk);
    endtask

    task automatic cw(input int hold);
        cur = (cur + 1) % 4;
        drive_ab(cw_seq[cur], hold);
    endtask

    task automatic ccw(input int hold);
        cur = (cur + 3) % 4;
        drive_ab(cw_seq[cur], hold);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int s0;
        cw_seq[0] = 2'b00;
        cw_seq[1] = 2'b10;
        cw_seq[2] = 2'b11;
        cw_seq[3] = 2'b01;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_dir", 32'(dir), 32'h0);
        chk("rst_step", 32'(step), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        // 8 full CW cycles
        s0 = step_seen;
        repeat (32) cw(10);
        chk("cw32_count", 32'(count), 32'd32);
        chk("cw32_dir", 32'(dir), 32'h1);
        chk("cw32_err", 32'(err), 32'h0);
        chk("cw32_steps", step_seen - s0, 32'd32);

        // 40 CCW transitions
        repeat (40) ccw(10);
        chk("ccw40_count", 32'(count), 32'hFFF8);
        chk("ccw40_dir", 32'(dir), 32'h2);

        // idle decay
        repeat (1030) @(negedge clk);
        chk("idle_dir", 32'(dir), 32'h0);
        chk("idle_count", 32'(count), 32'hFFF8);

        // 2-cycle glitch on A is filtered out
        s0 = step_seen;
        A = 1'b1;
        repeat (2) @(negedge clk);
        A = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch2_count", 32'(count), 32'hFFF8);
        chk("glitch2_steps", step_seen - s0, 32'd0);
        chk("glitch2_err", 32'(err), 32'h0);

        // 3-cycle pulse on A passes and produces a CW step (and later the step back)
        s0 = step_seen;
        A = 1'b1;
        repeat (3) @(negedge clk);
        A = 1'b0;
        repeat (3) @(negedge clk);
        chk("glitch3_count", 32'(count), 32'hFFF9);
        chk("glitch3_steps", step_seen - s0, 32'd1);
        repeat (10) @(negedge clk);
        chk("glitch3_back", 32'(count), 32'hFFF8);

        // illegal 00 -> 11
        drive_ab(2'b11, 10);
        cur = 2;
        chk("jump_err", 32'(err), 32'h1);
        chk("jump_count", 32'(count), 32'hFFF8);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        chk("errclr_err", 32'(err), 32'h0);

        // err_clr coincident with illegal 10 -> 01: set wins
        ccw(10);
        A = 1'b0;
        B = 1'b1;
        cur = 3;
        repeat (5) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        repeat (4) @(negedge clk);
        chk("setwins_err", 32'(err), 32'h1);
        chk("setwins_count", 32'(count), 32'hFFF7);

        // wrap at the positive limit
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk("clr_count", 32'(count), 32'h0);
        repeat (32767) cw(2);
        repeat (8) @(negedge clk);
        chk("pre_wrap", 32'(count), 32'h7FFF);
        cw(10);
        chk("wrap_up", 32'(count), 32'h8000);
        ccw(10);
        chk("wrap_down", 32'(count), 32'h7FFF);

        // clr on the same edge as a step
        cur = (cur + 1) % 4;
        A = cw_seq[cur][1];
        B = cw_seq[cur][0];
        repeat (5) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("clrstep_count", 32'(count), 32'h0);
        chk("clrstep_step", 32'(step), 32'h1);
        chk("clrstep_dir", 32'(dir), 32'h1);
        clr = 1'b0;
        repeat (6) @(negedge clk);

`ifdef QUAD_DECODER_INDEX_EN
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (57) cw(4);
        repeat (8) @(negedge clk);
        chk("idx_pre", 32'(count), 32'd57);
        s0 = idx_seen;
        Z = 1'b1;
        repeat (5) @(negedge clk);
        Z = 1'b0;
        repeat (10) @(negedge clk);
        chk("idx_count", 32'(count), 32'h0);
        chk("idx_pulses", idx_seen - s0, 32'd1);
        repeat (5) cw(4);
        repeat (8) @(negedge clk);
        chk("idxclr_pre", 32'(count), 32'd5);
        Z = 1'b1;
        repeat (5) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("idxclr_count", 32'(count), 32'h0);
        chk("idxclr_idx", 32'(idx), 32'h1);
        Z = 1'b0;
        repeat (10) @(negedge clk);
`endif

        // reset while the encoder rests at 11: exactly one err after filtering
        drive_ab(2'b11, 10);
        cur = 2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_count", 32'(count), 32'h0);
        chk("midrst_err", 32'(err), 32'h0);
        s0 = step_seen;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_err", 32'(err), 32'h1);
        chk("post_rst_count", 32'(count), 32'h0);
        chk("post_rst_steps", step_seen - s0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
